// File: rtl/fadd_sched.sv
// fadd_sched: round-robin scheduler sharing one fp add/sub pipeline among NREQ requesters.
// Optional macro FADD_SCHED_PERF_EN adds saturating per-requester issue counters (perf_cnt).
module fadd_sched #(
   parameter int NREQ = 4,
   parameter int LAT  = 7,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sched_en,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   input  logic [NREQ-1:0]      req_op,
   output logic [31:0]          fa_v1,
   output logic [31:0]          fa_v2,
   output logic                 fa_op,
   input  logic [31:0]          fa_vres,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_data,
`ifdef FADD_SCHED_PERF_EN
   output logic [NREQ*16-1:0]   perf_cnt,
`endif
   output logic                 busy
);

   logic [IDW-1:0]        ptr_q, ptr_d;
   logic [IDW-1:0]        gnt_id, sel, tag_id_d;
   logic                  issue;
   int                    idx;

   logic [31:0]           fa_v1_q, fa_v2_q;
   logic                  fa_op_q;
   logic [LAT:0]          vld_q;
   logic [LAT:0][IDW-1:0] tid_q;
   logic                  rsp_valid_q;
   logic [IDW-1:0]        rsp_id_q;
   logic [31:0]           rsp_data_q;

   // Grant is a pure function of req_valid, sched_en and ptr; the first valid at or after ptr wins.
   always_comb begin
      req_ready = '0;
      gnt_id    = '0;
      issue     = 1'b0;
      sel       = '0;
      idx       = 0;
      if (sched_en) begin
         for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = IDW'(idx);
            if (!issue && req_valid[sel]) begin
               issue  = 1'b1;
               gnt_id = sel;
            end
         end
      end
      if (issue) req_ready[gnt_id] = 1'b1;
   end

   always_comb begin
      ptr_d    = ptr_q;
      tag_id_d = '0;
      if (issue) begin
         ptr_d    = (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + 1'b1;
         tag_id_d = gnt_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         fa_v1_q     <= '0;
         fa_v2_q     <= '0;
         fa_op_q     <= 1'b0;
         vld_q       <= '0;
         tid_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (issue) begin
            fa_v1_q <= req_a[32*gnt_id +: 32];
            fa_v2_q <= req_b[32*gnt_id +: 32];
            fa_op_q <= req_op[gnt_id];
         end
         // Final tag stage lines up with fa_vres; stale datapath output is masked by vld=0.
         vld_q       <= {vld_q[LAT-1:0], issue};
         tid_q       <= {tid_q[LAT-1:0], tag_id_d};
         rsp_valid_q <= vld_q[LAT];
         rsp_id_q    <= tid_q[LAT];
         if (vld_q[LAT]) rsp_data_q <= fa_vres;
      end
   end

   assign fa_v1     = fa_v1_q;
   assign fa_v2     = fa_v2_q;
   assign fa_op     = fa_op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (|vld_q) | rsp_valid_q;

`ifdef FADD_SCHED_PERF_EN
   logic [NREQ-1:0][15:0] perf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
      end else if (issue && perf_q[gnt_id] != 16'hFFFF) begin
         perf_q[gnt_id] <= perf_q[gnt_id] + 16'd1;
      end
   end

   assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_fadd_sched.sv
// Self-checking bench for fadd_sched: directed vector table, corner sequences and a
// random phase checked against a queue-based issue/response model with an fp adder stand-in.
module tb_fadd_sched;
   localparam int NREQ = 4;
   localparam int LAT  = 7;
   localparam int IDW  = 2;
   localparam int AW   = NREQ*32;

   logic            clk = 1'b0;
   logic            rst, sched_en;
   logic [NREQ-1:0] req_valid, req_ready, req_op;
   logic [AW-1:0]   req_a, req_b;
   logic [31:0]     fa_v1, fa_v2, fa_vres, rsp_data;
   logic            fa_op, rsp_valid, busy;
   logic [IDW-1:0]  rsp_id;
`ifdef FADD_SCHED_PERF_EN
   logic [NREQ*16-1:0] perf_cnt;
`endif

   always #5 clk = ~clk;

   fadd_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .sched_en(sched_en),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .fa_v1(fa_v1), .fa_v2(fa_v2), .fa_op(fa_op), .fa_vres(fa_vres),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
`ifdef FADD_SCHED_PERF_EN
      .perf_cnt(perf_cnt),
`endif
      .busy(busy)
   );

   // ---- behavioural float helpers (exact for the small-integer operands used here) ----
   function automatic real f2r(input logic [31:0] f);
      real m;
      int  e;
      if (f[30:23] == 8'd0) return 0.0;
      m = 1.0 + real'(f[22:0]) / 8388608.0;
      e = int'(f[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return f[31] ? -m : m;
   endfunction

   function automatic logic [31:0] r2f(input real r);
      real         a;
      int          e;
      logic        s;
      logic [22:0] fr;
      logic [7:0]  eb;
      if (r == 0.0) return 32'h0;
      s = (r < 0.0);
      a = s ? -r : r;
      e = 0;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      fr = 23'($rtoi((a - 1.0) * 8388608.0));
      eb = 8'(e + 127);
      return {s, eb, fr};
   endfunction

   function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b, input logic op);
      return r2f(op ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
   endfunction

   // Datapath stand-in: LAT register stages from fa_* to fa_vres.
   logic [31:0] dp_q [LAT];
   initial for (int i = 0; i < LAT; i++) dp_q[i] = 32'h0;
   always @(posedge clk) begin
      dp_q[0] <= fp_ref(fa_v1, fa_v2, fa_op);
      for (int i = 1; i < LAT; i++) dp_q[i] <= dp_q[i-1];
   end
   assign fa_vres = dp_q[LAT-1];

   // ---- reference model and scoreboard ----
   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   dut_gnt[$];
   int   rsp_ids[$];
   int   rsp_cyc[$];
   int   mptr = 0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   chk_en = 1'b0;
   int   pcnt [NREQ];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic flag(input string nm);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // One clock: check grant before the edge, update model, check response side after it.
   task automatic tick();
      int              g;
      logic [NREQ-1:0] er, hs, tmp;
      logic [31:0]     a, b;
      exp_t            e;
      bit              exp_busy;
      #1;
      g = -1;
      if (sched_en) begin
         for (int off = 0; off < NREQ; off++) begin
            tmp = req_valid >> ((mptr + off) % NREQ);
            if (g < 0 && tmp[0]) g = (mptr + off) % NREQ;
         end
      end
      er = (g >= 0) ? (NREQ'(1) << g) : '0;
      if (chk_en && !rst) begin
         chk("req_ready", 32'(req_ready), 32'(er));
         hs = req_ready & req_valid;
         for (int k = 0; k < NREQ; k++) begin
            tmp = hs >> k;
            if (tmp[0]) dut_gnt.push_back(k);
         end
      end
      if (g >= 0 && !rst) begin
         a = 32'(req_a >> (32*g));
         b = 32'(req_b >> (32*g));
         tmp = req_op >> g;
         e.id = g; e.data = fp_ref(a, b, tmp[0]); e.due = cyc + LAT + 2;
         exp_q.push_back(e);
         mptr = (g + 1) % NREQ;
         pcnt[g]++;
      end
      @(posedge clk);
      cyc++;
      if (rst) begin
         exp_q.delete();
         mptr = 0;
         for (int k = 0; k < NREQ; k++) pcnt[k] = 0;
      end
      #1;
      if (chk_en) begin
         exp_busy = (exp_q.size() > 0);
         if (rsp_valid) begin
            rsp_ids.push_back(int'(rsp_id));
            rsp_cyc.push_back(cyc);
            if (exp_q.size() == 0) flag("unexpected rsp_valid");
            else begin
               e = exp_q.pop_front();
               chk("rsp_id", 32'(rsp_id), 32'(e.id));
               chk("rsp_data", rsp_data, e.data);
               chk("rsp_time", 32'(cyc), 32'(e.due));
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            flag("missing rsp_valid");
            void'(exp_q.pop_front());
         end
         chk("busy", 32'(busy), 32'(exp_busy));
      end
   endtask

   task automatic idle_inputs();
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin tick(); n++; end
      if (busy) flag("timeout waiting for idle");
   endtask

   task automatic rand_operands();
      for (int k = 0; k < NREQ; k++) begin
         req_a[32*k +: 32] = r2f(real'($urandom_range(0, 1023)));
         req_b[32*k +: 32] = r2f(real'($urandom_range(0, 1023)));
      end
      req_op = NREQ'($urandom);
   endtask

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] res;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int t0, seen, lastr, nissue, nrsp;

      vecs[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
      vecs[1] = '{2, 32'h40000000, 32'h40000000, 1'b1, 32'h00000000};
      vecs[2] = '{3, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000};
      vecs[3] = '{1, 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000};
      for (int k = 0; k < NREQ; k++) pcnt[k] = 0;

      // Reset
      idle_inputs();
      sched_en = 1'b1;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("reset fa_v1", fa_v1, 32'h0);
      chk("reset fa_v2", fa_v2, 32'h0);
      chk("reset fa_op", 32'(fa_op), 32'h0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset rsp_id", 32'(rsp_id), 32'h0);
      chk("reset rsp_data", rsp_data, 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset req_ready", 32'(req_ready), 32'h0);
      chk_en = 1'b1;

      // Directed vector table: single op each, latency and result checked
      foreach (vecs[i]) begin
         idle_inputs();
         req_valid = NREQ'(1) << vecs[i].id;
         req_a     = AW'(vecs[i].a) << (32*vecs[i].id);
         req_b     = AW'(vecs[i].b) << (32*vecs[i].id);
         req_op    = NREQ'(vecs[i].op) << vecs[i].id;
         t0 = cyc;
         tick();
         idle_inputs();
         seen = 0;
         for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (rsp_valid) begin
               seen = 1;
               chk("vec rsp_data", rsp_data, vecs[i].res);
               chk("vec rsp_id", 32'(rsp_id), 32'(vecs[i].id));
               chk("vec latency", 32'(cyc - t0), 32'(LAT + 2));
            end
         end
         if (!seen) flag("vec timeout");
         wait_idle(20);
      end

      // Fairness from ptr=0
      rst = 1'b1; tick(); rst = 1'b0;
      dut_gnt.delete(); rsp_ids.delete(); rsp_cyc.delete();
      rand_operands();
      req_valid = '1;
      repeat (8) tick();
      idle_inputs();
      wait_idle(30);
      chk("fair grant count", 32'(dut_gnt.size()), 32'd8);
      chk("fair rsp count", 32'(rsp_ids.size()), 32'd8);
      for (int i = 0; i < 8 && i < dut_gnt.size() && i < rsp_ids.size(); i++) begin
         chk("fair grant order", 32'(dut_gnt[i]), 32'(i % 4));
         chk("fair rsp order", 32'(rsp_ids[i]), 32'(i % 4));
         chk("fair back-to-back", 32'(rsp_cyc[i] - rsp_cyc[0]), 32'(i));
      end

      // Single active requester granted every cycle
      dut_gnt.delete();
      rand_operands();
      req_valid = 4'b0100;
      repeat (5) tick();
      idle_inputs();
      chk("single grant count", 32'(dut_gnt.size()), 32'd5);
      foreach (dut_gnt[i]) chk("single grant id", 32'(dut_gnt[i]), 32'd2);
      wait_idle(30);

      // Random load, then drain with sched_en=0
      for (int n = 0; n < 300; n++) begin
         rand_operands();
         req_valid = NREQ'($urandom);
         sched_en  = ($urandom_range(0, 9) != 0);
         tick();
      end
      sched_en = 1'b1;
      dut_gnt.delete(); rsp_ids.delete(); rsp_cyc.delete();
      for (int n = 0; n < 20; n++) begin
         rand_operands();
         req_valid = '1;
         tick();
      end
      nissue = dut_gnt.size() + exp_q.size() - 20;
      sched_en = 1'b0;
      rsp_ids.delete(); rsp_cyc.delete();
      nissue = exp_q.size();
      lastr = -1;
      for (int n = 0; n < 30 && busy; n++) begin
         tick();
         if (rsp_valid) lastr = cyc;
      end
      if (busy) flag("drain timeout");
      chk("drain rsp count", 32'(rsp_ids.size()), 32'(nissue));
      chk("drain busy fall", 32'(cyc - lastr), 32'd1);
      repeat (3) tick();
      idle_inputs();
      sched_en = 1'b1;

      // Reset with ops in flight
      rsp_ids.delete();
      rand_operands();
      req_valid = 4'b1011;
      repeat (3) tick();
      idle_inputs();
      repeat (2) tick();
      rst = 1'b1;
      tick();
      chk("rst-in-flight busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      nrsp = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (rsp_valid) nrsp++;
      end
      chk("rst-in-flight rsp", 32'(nrsp), 32'd0);
      chk("rst-in-flight rsp log", 32'(rsp_ids.size()), 32'd0);

`ifdef FADD_SCHED_PERF_EN
      rst = 1'b1; tick(); rst = 1'b0;
      rand_operands();
      req_valid = 4'b1101;
      repeat (7) tick();
      req_valid = 4'b0010;
      repeat (70000) tick();
      req_valid = 4'b0011;
      repeat (6) tick();
      idle_inputs();
      wait_idle(30);
      for (int k = 0; k < NREQ; k++)
         chk("perf_cnt", 32'(perf_cnt[16*k +: 16]), (pcnt[k] > 65535) ? 32'hFFFF : 32'(pcnt[k]));
      chk("perf_cnt[1] saturated", 32'(perf_cnt[31:16]), 32'hFFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #8000000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fadd_sched.md
Name: fadd_sched

Overview:
- Round-robin scheduler that shares one float_addsub pipeline among NREQ requesters.
- Each requester has a valid/ready request port. The granted operands are registered into the shared datapath, and a requester-id tag travels alongside each op through a shift register.
- The result is returned with its id after a fixed latency.
- Sits between the vector/scalar issue units and the single fp add/sub instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 7, cycles from fa_v1/fa_v2/fa_op changing to the matching fa_vres being valid.
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sched_en  in  1  1 = grants allowed; 0 = no new grants, in-flight ops drain
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; combinational; at most one bit set
- req_a  in  NREQ*32  operand A of requester i at [32i+31:32i]
- req_b  in  NREQ*32  operand B, same packing
- req_op  in  NREQ  0 = add, 1 = subtract (A-B)
- fa_v1  out  32  to datapath v1
- fa_v2  out  32  to datapath v2
- fa_op  out  1  to datapath op
- fa_vres  in  32  from datapath vres
- rsp_valid  out  1  result valid, single-cycle pulse per op
- rsp_id  out  IDW  requester id of the result
- rsp_data  out  32  result
- busy  out  1  any op in flight or rsp_valid high

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and has priority over all other logic.
- Reset values:
  - ptr=0, tag pipeline cleared.
  - fa_v1=fa_v2=0, fa_op=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- Reset mid-operation: all in-flight ops are discarded and no rsp is produced for them. The datapath itself is not reset, so its stale outputs are ignored via the cleared tags.
- Arbitration:
  - When sched_en=1, scan req_valid starting at index ptr, wrapping modulo NREQ.
  - The first set bit k gets req_ready[k]=1. Issue occurs on cycle t when req_valid[k] & req_ready[k].
  - On issue, ptr <= (k+1) mod NREQ. With no issue, ptr holds.
  - sched_en=0 or no valid request: req_ready=0.
  - req_ready depends on req_valid, sched_en and ptr only. Requesters must not make req_valid depend on req_ready.
  - Throughput: one issue per cycle, with no bubbles under continuous load.
- Issue register:
  - At the issue edge, fa_v1<=req_a[k], fa_v2<=req_b[k], fa_op<=req_op[k].
  - With no issue, fa_* hold their previous values; the result is discarded because the tag is invalid.
- Tag pipeline:
  - Shift register of {vld, id}, length LAT+1. Stage 0 is loaded at the issue edge with {1,k}, or {0,0} with no issue.
  - The final stage aligns with fa_vres.
- Response:
  - rsp_valid, rsp_id and rsp_data are registered from the final tag stage and fa_vres.
  - An op issued at edge t produces rsp_valid=1 at t+LAT+2.
  - Responses come out in issue order and cannot be back-pressured.
  - rsp_data is updated only when the final tag is valid; otherwise it holds.
- busy: OR of all tag-stage vld bits and rsp_valid.
- sched_en deasserted mid-stream: in-flight ops complete normally; busy falls one cycle after the last rsp_valid.
- Boundaries:
  - NREQ not a power of two: ptr wraps at NREQ-1 -> 0.
  - A single active requester is granted every cycle.
  - A request deasserting req_valid before being granted is legal and leaves no trace.

Optional Feature:
- Macro: FADD_SCHED_PERF_EN.
- Defined:
  - Adds output perf_cnt, NREQ*16 wide. perf_cnt[16i+15:16i] counts issues of requester i, saturating at 16'hFFFF.
  - Cleared by rst; counters are registered and increment at the issue edge.
- Undefined: the port and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset: rst high 2 cycles -> all outputs 0, req_ready=0. Then req_valid=4'b0001, A=32'h3F800000, B=32'h40000000, op=0 at edge t -> rsp_valid at t+9 (LAT=7), rsp_id=0, rsp_data=32'h40400000.
- Fairness: all four req_valid held high for 8 cycles, ptr=0 -> grant order 0,1,2,3,0,1,2,3; responses arrive back-to-back, ids in the same order.
- Subtract and sign: requester 2, A=32'h40000000, B=32'h40000000, op=1 -> rsp_id=2, rsp_data=32'h00000000. Requester 3, A=1.0, B=2.0, op=1 -> rsp_data=32'hBF800000.
- Drain: continuous load, then sched_en=0 at cycle c -> req_ready=0 from c; exactly the already-issued ops respond; busy falls one cycle after the last rsp_valid.
- Reset in flight: issue 3 ops, assert rst 2 cycles later -> no rsp_valid ever for them; busy=0 the cycle after rst.
- Perf (FADD_SCHED_PERF_EN): requester 1 issues 70000 times -> perf_cnt[31:16]=16'hFFFF and holds; the other counters keep correct counts.
